// File: rtl/pwm_tone_generator.sv
// Phase-accumulator tone generator gated by a fixed-period PWM carrier.
// Each note change inserts GAP_CYCLES of silence before the new note plays.
module pwm_tone_generator #(
    parameter int unsigned PHASE_WIDTH = 32,
    parameter int unsigned TOP_WIDTH   = 8,
    parameter int unsigned GAP_CYCLES  = 250_000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [TOP_WIDTH-1:0]   i_top,
    input  logic                   i_top_valid,
    input  logic [PHASE_WIDTH-1:0] i_phase_delta,
    output logic                   o_pwm,
    output logic                   o_note_on,
    output logic                   o_period_start
);

    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
    localparam bit          HAS_GAP  = (GAP_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_PLAY = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [TOP_WIDTH-1:0]   count_q, count_d;
    logic [TOP_WIDTH-1:0]   pending_q, pending_d;
    logic [TOP_WIDTH-1:0]   active_q, active_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] held_q, held_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic                   pwm_q, pwm_d;
    logic                   note_on_q, note_on_d;
    logic                   period_start_q, period_start_d;
    state_e                 note_entry;

    // A changed note either waits out the gap or, with no gap, restarts immediately.
    assign note_entry = HAS_GAP ? ST_GAP : ST_PLAY;

    // Note sequencing FSM: next state, held delta, phase and gap counter.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        gap_d   = gap_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (i_phase_delta != '0) begin
                    held_d  = i_phase_delta;
                    gap_d   = GAP_W'(GAP_LAST);
                    state_d = note_entry;
                end
            end
            ST_PLAY: begin
                if (i_phase_delta == held_q) begin
                    phase_d = phase_q + held_q;
                end else if (i_phase_delta == '0) begin
                    held_d  = '0;
                    phase_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    held_d  = i_phase_delta;
                    phase_d = '0;
                    gap_d   = GAP_W'(GAP_LAST);
                    state_d = note_entry;
                end
            end
            ST_GAP: begin
                phase_d = '0;
                if (i_phase_delta == '0) begin
                    held_d  = '0;
                    state_d = ST_IDLE;
                end else if (i_phase_delta != held_q) begin
                    held_d = i_phase_delta;
                    gap_d  = GAP_W'(GAP_LAST);
                end else if (gap_q == '0) begin
                    state_d = ST_PLAY;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
                held_d  = '0;
            end
        endcase
    end

    // Carrier, level hand-over at the period boundary, and output drive.
    always_comb begin
        count_d        = count_q + TOP_WIDTH'(1);
        pending_d      = i_top_valid ? i_top : pending_q;
        active_d       = (count_q == '1) ? pending_d : active_q;
        period_start_d = (count_q == '0);
        pwm_d          = (state_q == ST_PLAY) & phase_q[PHASE_WIDTH-1] & (count_q < active_q);
        note_on_d      = (state_d == ST_PLAY);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            pending_q      <= '0;
            active_q       <= '0;
            phase_q        <= '0;
            held_q         <= '0;
            gap_q          <= '0;
            pwm_q          <= 1'b0;
            note_on_q      <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            pending_q      <= pending_d;
            active_q       <= active_d;
            phase_q        <= phase_d;
            held_q         <= held_d;
            gap_q          <= gap_d;
            pwm_q          <= pwm_d;
            note_on_q      <= note_on_d;
            period_start_q <= period_start_d;
        end
    end

    assign o_pwm          = pwm_q;
    assign o_note_on      = note_on_q;
    assign o_period_start = period_start_q;

endmodule

// File: tb/tb_pwm_tone_generator.sv
// Directed plus randomized bench for pwm_tone_generator against a note-level model.
module tb_pwm_tone_generator;

    localparam int unsigned PW  = 32;
    localparam int unsigned TW  = 8;
    localparam int unsigned GAP = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [TW-1:0] top;
    logic          top_valid;
    logic [PW-1:0] delta;
    logic          pwm, note_on, period_start;

    int vectors     = 0;
    int miscompares = 0;

    // Model: a note is "sounding" once its delta is held and its silence has run out.
    logic [TW-1:0] m_count, m_pending, m_active;
    logic [PW-1:0] m_phase, m_note;
    int            m_silent;
    logic          e_pwm, e_note, e_ps;

    always #5 clk = ~clk;

    pwm_tone_generator #(
        .PHASE_WIDTH(PW),
        .TOP_WIDTH  (TW),
        .GAP_CYCLES (GAP)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_top         (top),
        .i_top_valid   (top_valid),
        .i_phase_delta (delta),
        .o_pwm         (pwm),
        .o_note_on     (note_on),
        .o_period_start(period_start)
    );

    task automatic model_update();
        logic sounding;
        if (!rst_n) begin
            m_count = '0; m_pending = '0; m_active = '0;
            m_phase = '0; m_note = '0; m_silent = 0;
            e_pwm = 1'b0; e_note = 1'b0; e_ps = 1'b0;
        end else begin
            sounding = (m_note != '0) && (m_silent == 0);
            e_pwm    = sounding && m_phase[PW-1] && (m_count < m_active);
            e_ps     = (m_count == '0);
            if (top_valid) m_pending = top;
            if (m_count == {TW{1'b1}}) m_active = m_pending;
            m_count = m_count + TW'(1);
            if (delta == '0) begin
                m_note = '0; m_silent = 0; m_phase = '0;
            end else if (delta != m_note) begin
                m_note = delta; m_silent = GAP; m_phase = '0;
            end else if (m_silent > 0) begin
                m_silent = m_silent - 1;
            end else begin
                m_phase = m_phase + m_note;
            end
            e_note = (m_note != '0) && (m_silent == 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        vectors++;
        assert (pwm === e_pwm) else begin
            miscompares++;
            $error("FAIL pwm t=%0t got %b exp %b", $time, pwm, e_pwm);
        end
        assert (note_on === e_note) else begin
            miscompares++;
            $error("FAIL note_on t=%0t got %b exp %b", $time, note_on, e_note);
        end
        assert (period_start === e_ps) else begin
            miscompares++;
            $error("FAIL period_start t=%0t got %b exp %b", $time, period_start, e_ps);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        m_count = '0; m_pending = '0; m_active = '0;
        m_phase = '0; m_note = '0; m_silent = 0;
        e_pwm = 1'b0; e_note = 1'b0; e_ps = 1'b0;

        // Reset held with active inputs, then first note with full level.
        rst_n = 1'b0; delta = 32'h4000_0000; top = 8'hFF; top_valid = 1'b1;
        run(5);
        rst_n = 1'b1;
        run(1);
        top_valid = 1'b0;
        run(599);

        // Level change mid-period takes effect only from the next wrap.
        for (int i = 0; i < 300 && m_count != 8'd10; i++) step();
        top = 8'h80; top_valid = 1'b1;
        run(1);
        top_valid = 1'b0;
        run(600);

        // Note change while playing, then changes and rests inside the gap.
        delta = 32'h2000_0000;
        run(100);
        delta = 32'h1000_0000;
        run(2);
        delta = 32'h0800_0000;
        run(20);
        delta = 32'h1000_0000;
        run(2);
        delta = '0;
        run(5);
        delta = 32'h4000_0000;
        run(30);
        delta = '0;
        run(5);

        // Reset in the middle of a gap, note still requested afterwards.
        delta = 32'h4000_0000;
        run(2);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        run(30);

        // Randomized notes, levels and occasional resets.
        for (int i = 0; i < 2500; i++) begin
            rst_n     = ($urandom_range(0, 499) != 0);
            top_valid = ($urandom_range(0, 7) == 0);
            top       = TW'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       delta = '0;
                    1:       delta = 32'h4000_0000;
                    2:       delta = 32'h2000_0000;
                    default: delta = PW'($urandom);
                endcase
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
